// File: rtl/mem_stage_dm_if.sv
// -----------------------------------------------------------------------------
// mem_stage_dm_if
// Bundle of the signals between the EX/MEM register, the MEM-stage data
// memory and the MEM/WB register.
//
// Signals:
//   IRIn     32  instruction in MEM, opcode in IRIn[31:26]
//   PCIn     32  PC of the MEM-stage instruction (logging only)
//   AddrIn   32  byte address from the EX/MEM ALU result
//   WDataIn  32  store data (forwarded rt)
//   RDataOut 32  extended load data towards MEM/WB
//   WEOut     1  high while a store is being committed this cycle
//
// Handshake: there is none. One instruction occupies MEM every cycle; the
// request fields are sampled as-is, RDataOut/WEOut follow combinationally
// and a store commits on the next rising clock edge.
//
// Modports:
//   master  pipeline side (drives the request, observes the results)
//   slave   data memory side
// -----------------------------------------------------------------------------
interface mem_stage_dm_if;
   logic [31:0] IRIn;
   logic [31:0] PCIn;
   logic [31:0] AddrIn;
   logic [31:0] WDataIn;
   logic [31:0] RDataOut;
   logic        WEOut;

   modport master (
      output IRIn,
      output PCIn,
      output AddrIn,
      output WDataIn,
      input  RDataOut,
      input  WEOut
   );

   modport slave (
      input  IRIn,
      input  PCIn,
      input  AddrIn,
      input  WDataIn,
      output RDataOut,
      output WEOut
   );
endinterface

// File: rtl/mem_stage_dm.sv
// -----------------------------------------------------------------------------
// mem_stage_dm
// MEM-stage data memory of the 5-stage pipelined CPU. Stores (sw/sh/sb)
// commit on the rising clock edge; loads (lw/lh/lhu/lb/lbu) return sign- or
// zero-extended data combinationally. Any other opcode is a no-op.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; the whole array reads 0 afterwards
//   bus    mem_stage_dm_if.slave (IRIn, PCIn, AddrIn, WDataIn -> RDataOut, WEOut)
//
// Parameters:
//   DEPTH_LOG2  log2 of the word count (default 4096 words = 16 KiB)
//
// Optional build macro:
//   DM_WRITE_LOG_EN  when defined, every committed store prints
//                    "@<pc>: *<word addr> <= <resulting word>" in simulation.
// -----------------------------------------------------------------------------
module mem_stage_dm #(
   parameter int DEPTH_LOG2 = 12
) (
   input  logic          clk,
   input  logic          reset,
   mem_stage_dm_if.slave bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   // Array clearing is done with one valid bit per word: reset clears the
   // valid vector in a single step and a word that is not valid reads as 0.
   // The data array itself therefore needs no reset.
   logic [31:0]      mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   logic [5:0]            opcode;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  is_store;
   logic                  we;
   logic [31:0]           cur_word;
   logic [15:0]           cur_half;
   logic [7:0]            cur_byte;
   logic [31:0]           wr_word;
   logic [31:0]           rd_data;

   assign opcode   = bus.IRIn[31:26];
   assign word_idx = bus.AddrIn[DEPTH_LOG2+1:2];

   assign is_store = (opcode == OP_SW) || (opcode == OP_SH) || (opcode == OP_SB);
   assign we       = is_store && !reset;

   // Current contents of the addressed word; forced to 0 during reset so the
   // clear is visible immediately, before any clock edge.
   assign cur_word = (!reset && valid_q[word_idx]) ? mem_q[word_idx] : 32'h0;
   assign cur_half = bus.AddrIn[1] ? cur_word[31:16] : cur_word[15:0];

   always_comb begin
      cur_byte = cur_word[7:0];
      case (bus.AddrIn[1:0])
         2'd0: cur_byte = cur_word[7:0];
         2'd1: cur_byte = cur_word[15:8];
         2'd2: cur_byte = cur_word[23:16];
         2'd3: cur_byte = cur_word[31:24];
         default: cur_byte = cur_word[7:0];
      endcase
   end

   // Merged word for sub-word stores: the untouched lanes come from the
   // current contents, so the array is always written a full word at a time.
   always_comb begin
      wr_word = cur_word;
      case (opcode)
         OP_SW: wr_word = bus.WDataIn;
         OP_SH: begin
            if (bus.AddrIn[1])
               wr_word[31:16] = bus.WDataIn[15:0];
            else
               wr_word[15:0]  = bus.WDataIn[15:0];
         end
         OP_SB: begin
            case (bus.AddrIn[1:0])
               2'd0: wr_word[7:0]   = bus.WDataIn[7:0];
               2'd1: wr_word[15:8]  = bus.WDataIn[7:0];
               2'd2: wr_word[23:16] = bus.WDataIn[7:0];
               2'd3: wr_word[31:24] = bus.WDataIn[7:0];
               default: wr_word     = cur_word;
            endcase
         end
         default: wr_word = cur_word;
      endcase
   end

   // Load data with extension; non-load opcodes (stores, bubbles, ALU ops)
   // return 0.
   always_comb begin
      rd_data = 32'h0;
      case (opcode)
         OP_LW:  rd_data = cur_word;
         OP_LH:  rd_data = {{16{cur_half[15]}}, cur_half};
         OP_LHU: rd_data = {16'h0, cur_half};
         OP_LB:  rd_data = {{24{cur_byte[7]}}, cur_byte};
         OP_LBU: rd_data = {24'h0, cur_byte};
         default: rd_data = 32'h0;
      endcase
   end

   assign bus.RDataOut = reset ? 32'h0 : rd_data;
   assign bus.WEOut    = we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[word_idx] <= 1'b1;
      end
   end

   // we already excludes reset, so a store coincident with reset is dropped.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[word_idx] <= wr_word;
      end
   end

`ifdef DM_WRITE_LOG_EN
   always @(posedge clk) begin
      if (we) begin
         $display("@%08h: *%08h <= %08h", bus.PCIn, {bus.AddrIn[31:2], 2'b00}, wr_word);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^bus.PCIn;
`endif

   // Instruction fields other than the opcode and the address bits above
   // the array are deliberately ignored.
   logic unused_bits;
   assign unused_bits = ^{bus.IRIn[25:0], bus.AddrIn[31:DEPTH_LOG2+2]};

endmodule

// File: tb/tb_mem_stage_dm.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_dm
// Directed testbench for mem_stage_dm with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mem_stage_dm;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_stage_dm_if bus ();

   mem_stage_dm #(.DEPTH_LOG2(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks;
   int n_fail;
   logic [31:0] pc;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   function automatic logic [31:0] mk_ir(input logic [5:0] op);
      return {op, 26'h0123456};
   endfunction

   // Apply one MEM-stage instruction at the falling edge; outputs are
   // sampled 1 time unit later, a store commits at the next rising edge.
   task automatic drive(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      bus.IRIn    = ir;
      bus.AddrIn  = addr;
      bus.WDataIn = wd;
      bus.PCIn    = pc;
      pc          = pc + 32'd4;
      #1;
   endtask

   task automatic load_chk(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] exp);
      drive(mk_ir(op), addr, 32'hA5A5_A5A5);
      check_eq(tag, bus.RDataOut, exp);
      check_eq({tag, "_we"}, {31'h0, bus.WEOut}, 32'h0);
   endtask

   task automatic store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
      drive(mk_ir(op), addr, wd);
      check_eq({tag, "_we"}, {31'h0, bus.WEOut}, 32'h1);
      check_eq({tag, "_rd"}, bus.RDataOut, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks    = 0;
      n_fail      = 0;
      pc          = 32'h0000_3000;
      reset       = 1'b1;
      bus.IRIn    = mk_ir(OP_SW);
      bus.AddrIn  = 32'h0000_0010;
      bus.WDataIn = 32'hFFFF_FFFF;
      bus.PCIn    = pc;

      // Store presented during reset must not be signalled.
      #2;
      check_eq("rst_we", {31'h0, bus.WEOut}, 32'h0);
      check_eq("rst_rd", bus.RDataOut, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.IRIn = mk_ir(OP_LW);
      reset    = 1'b0;

      load_chk("lw_after_rst", OP_LW, 32'h0000_0010, 32'h0000_0000);

      // Word store then readback
      store("sw20", OP_SW, 32'h0000_0020, 32'h1234_5678);
      load_chk("lw20", OP_LW, 32'h0000_0020, 32'h1234_5678);

      // Byte store into lane 2 and sub-word reads
      store("sb22", OP_SB, 32'h0000_0022, 32'h0000_00AB);
      load_chk("lw20_sb", OP_LW,  32'h0000_0020, 32'h12AB_5678);
      load_chk("lb22",    OP_LB,  32'h0000_0022, 32'hFFFF_FFAB);
      load_chk("lbu22",   OP_LBU, 32'h0000_0022, 32'h0000_00AB);
      load_chk("lb20",    OP_LB,  32'h0000_0020, 32'h0000_0078);
      load_chk("lb23",    OP_LB,  32'h0000_0023, 32'h0000_0012);
      load_chk("lb21",    OP_LBU, 32'h0000_0021, 32'h0000_0056);
      load_chk("lh22",    OP_LH,  32'h0000_0022, 32'h0000_12AB);
      load_chk("lhu20",   OP_LHU, 32'h0000_0020, 32'h0000_5678);

      // Halfword store into the upper half of a zeroed word
      store("sh26", OP_SH, 32'h0000_0026, 32'h0000_8001);
      load_chk("lw24",   OP_LW,  32'h0000_0024, 32'h8001_0000);
      load_chk("lh26",   OP_LH,  32'h0000_0026, 32'hFFFF_8001);
      load_chk("lhu27",  OP_LHU, 32'h0000_0027, 32'h0000_8001);
      load_chk("lh24",   OP_LH,  32'h0000_0024, 32'h0000_0000);

      // Lower-half store with odd address and junk upper data bits
      store("sh25", OP_SH, 32'h0000_0025, 32'hFFFF_7FFE);
      load_chk("lw24_sh", OP_LW, 32'h0000_0024, 32'h8001_7FFE);
      load_chk("lh24_b",  OP_LH, 32'h0000_0024, 32'h0000_7FFE);

      // Address wrap modulo 16 KiB
      store("sw4004", OP_SW, 32'h0000_4004, 32'hDEAD_BEEF);
      load_chk("lw4_wrap", OP_LW, 32'h0000_0004, 32'hDEAD_BEEF);
      load_chk("lw_hi_wrap", OP_LW, 32'hFFFF_C004, 32'hDEAD_BEEF);

      // Misaligned word store ignores the low bits; sb ignores upper data
      store("sw2b", OP_SW, 32'h0000_002B, 32'hCAFE_F00D);
      load_chk("lw28", OP_LW, 32'h0000_0028, 32'hCAFE_F00D);
      store("sb28", OP_SB, 32'h0000_0028, 32'hFFFF_FF11);
      load_chk("lw28_sb", OP_LW, 32'h0000_0028, 32'hCAFE_F011);
      store("sb2b", OP_SB, 32'h0000_002B, 32'h0000_0099);
      load_chk("lw28_sb3", OP_LW, 32'h0000_0028, 32'h99FE_F011);

      // Bubble and a non-memory opcode: no write, RDataOut = 0
      drive(32'h0, 32'h0000_0020, 32'hFFFF_FFFF);
      check_eq("bubble_we", {31'h0, bus.WEOut}, 32'h0);
      check_eq("bubble_rd", bus.RDataOut, 32'h0);
      drive(mk_ir(OP_ADDI), 32'h0000_0020, 32'hFFFF_FFFF);
      check_eq("addi_we", {31'h0, bus.WEOut}, 32'h0);
      check_eq("addi_rd", bus.RDataOut, 32'h0);
      load_chk("lw20_bubble", OP_LW, 32'h0000_0020, 32'h12AB_5678);

      // Reset between clock edges clears immediately; coincident store lost
      #1;
      reset = 1'b1;
      #1;
      check_eq("rst_mid_rd", bus.RDataOut, 32'h0);
      bus.IRIn    = mk_ir(OP_SW);
      bus.AddrIn  = 32'h0000_0020;
      bus.WDataIn = 32'h5555_5555;
      #1;
      check_eq("rst_mid_we", {31'h0, bus.WEOut}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.IRIn = mk_ir(OP_LW);
      reset    = 1'b0;
      #1;
      check_eq("lw20_post_rst", bus.RDataOut, 32'h0);
      load_chk("lw4_post_rst",  OP_LW, 32'h0000_0004, 32'h0000_0000);
      load_chk("lw24_post_rst", OP_LW, 32'h0000_0024, 32'h0000_0000);

      // Operation resumes after reset
      store("sw30", OP_SW, 32'h0000_0030, 32'h0BAD_F00D);
      load_chk("lw30", OP_LW, 32'h0000_0030, 32'h0BAD_F00D);
      store("sb20_post", OP_SB, 32'h0000_0021, 32'h0000_00C3);
      load_chk("lw20_sb_post", OP_LW, 32'h0000_0020, 32'h0000_C300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net against a stalled run
   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected completion by 100000");
      $fatal(1);
   end

endmodule
